// File: rtl/sc_lane_shifter_pkg.sv
// Shared definitions for the lane shifter: FSM state and direction encodings.
package sc_lane_shifter_pkg;

    // Lane controller states; HOLD freezes the row, IDLE waits for the first load
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } lane_state_e;

    // Rotation direction as seen on SC_LANE_DIR_In
    localparam logic DIR_MSB = 1'b0;
    localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/sc_lane_shifter_prescaler.sv
// Tick prescaler: counts accepted ticks 0..TICKS_PER_STEP-1 and strobes on the
// tick that completes a step. The strobe is combinational so the owner can
// rotate in the same cycle the last tick arrives.
module sc_tick_prescaler #(
    parameter int TICKS_PER_STEP = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic tick_i,
    input  logic enable_i,
    output logic step_o
);

    localparam int CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Strobe on the final tick of a step; a clear always suppresses it
    always_comb begin
        step_o = enable_i & tick_i & ~clear_i & (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (enable_i & tick_i)
            cnt_d = step_o ? '0 : cnt_q + 1'b1;
    end

    // Prescale counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/sc_lane_shifter.sv
// Traffic lane shifter: rotates a vehicle row one cell per TICKS_PER_STEP
// speed ticks, gates the upstream divider via TICK_EN, and flags a hit when
// the player column lands on a lit cell. All outputs are registered.
module sc_lane_shifter
    import sc_lane_shifter_pkg::*;
#(
    parameter int                    LANE_WIDTH     = 8,
    parameter int                    POS_WIDTH      = 3,
    parameter int                    TICKS_PER_STEP = 1,
    parameter logic [LANE_WIDTH-1:0] ROW_RESET      = '0
) (
    input  logic                  SC_LANE_CLOCK_50,
    input  logic                  SC_LANE_RESET_InLow,
    input  logic                  SC_LANE_TICK_In,
    input  logic                  SC_LANE_RUN_In,
    input  logic                  SC_LANE_LOAD_In,
    input  logic [LANE_WIDTH-1:0] SC_LANE_PATTERN_In,
    input  logic                  SC_LANE_DIR_In,
    input  logic [POS_WIDTH-1:0]  SC_LANE_POS_In,
    input  logic                  SC_LANE_POS_VALID_In,
    output logic                  SC_LANE_TICK_EN_Out,
    output logic [LANE_WIDTH-1:0] SC_LANE_ROW_Out,
    output logic                  SC_LANE_STEP_Out,
    output logic                  SC_LANE_HIT_Out
);

    lane_state_e           state_q, state_d;
    logic [LANE_WIDTH-1:0] row_q, row_d;
    logic                  tick_en_q, step_q, hit_q, hit_d;
    logic                  step_now;

    // Ticks only count while running; a load clears the count and drops the tick
    sc_tick_prescaler #(
        .TICKS_PER_STEP(TICKS_PER_STEP)
    ) u_prescaler (
        .clk_i    (SC_LANE_CLOCK_50),
        .rst_ni   (SC_LANE_RESET_InLow),
        .clear_i  (SC_LANE_LOAD_In),
        .tick_i   (SC_LANE_TICK_In),
        .enable_i (state_q == ST_RUN),
        .step_o   (step_now)
    );

    // Next state, next row and the hit seen against the next row
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        hit_d   = 1'b0;

        case (state_q)
            ST_IDLE: if (SC_LANE_LOAD_In) state_d = SC_LANE_RUN_In ? ST_RUN : ST_HOLD;
            ST_RUN,
            ST_HOLD: state_d = SC_LANE_RUN_In ? ST_RUN : ST_HOLD;
            default: state_d = ST_IDLE;
        endcase

        if (SC_LANE_LOAD_In)
            row_d = SC_LANE_PATTERN_In;
        else if (step_now)
            row_d = (SC_LANE_DIR_In == DIR_LSB) ? {row_q[0], row_q[LANE_WIDTH-1:1]}
                                                : {row_q[LANE_WIDTH-2:0], row_q[LANE_WIDTH-1]};

        // Only in-range columns can match, so an out-of-range POS yields no hit
        for (int i = 0; i < LANE_WIDTH; i++)
            if (SC_LANE_POS_VALID_In && (int'(SC_LANE_POS_In) == i))
                hit_d = row_d[i];
    end

    // State, row and registered outputs; TICK_EN follows the next state
    always_ff @(posedge SC_LANE_CLOCK_50 or negedge SC_LANE_RESET_InLow) begin
        if (!SC_LANE_RESET_InLow) begin
            state_q   <= ST_IDLE;
            row_q     <= ROW_RESET;
            tick_en_q <= 1'b0;
            step_q    <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            tick_en_q <= (state_d == ST_RUN);
            step_q    <= step_now;
            hit_q     <= hit_d;
        end
    end

    assign SC_LANE_TICK_EN_Out = tick_en_q;
    assign SC_LANE_ROW_Out     = row_q;
    assign SC_LANE_STEP_Out    = step_q;
    assign SC_LANE_HIT_Out     = hit_q;

endmodule
